// File: rtl/ysyx_23060332_ifu_if.sv
// ----------------------------------------------------------------------------
// ysyx_23060332_ifu_if
// Bundles the fetch unit's bus-side signals so they can be passed as a
// single port.
//   imem_req_valid/addr/ready : request channel to instruction memory
//   imem_resp_valid/data      : single-cycle response pulse from memory
//   inst_o/inst_addr_o/inst_valid_o/inst_ready_i : handoff to decode
//   jump_flag_i/jump_addr_i   : next-PC redirect, sampled at handoff
//   fetch_err_o               : sticky protocol/alignment error
// The master modport is the fetch unit. The slave modport is the
// memory/decode side.
// ----------------------------------------------------------------------------
interface ysyx_23060332_ifu_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        fetch_err_o;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        output inst_o,
        output inst_addr_o,
        output inst_valid_o,
        input  inst_ready_i,
        input  jump_flag_i,
        input  jump_addr_i,
        output fetch_err_o
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        input  inst_o,
        input  inst_addr_o,
        input  inst_valid_o,
        output inst_ready_i,
        output jump_flag_i,
        output jump_addr_i,
        input  fetch_err_o
    );
endinterface

// File: rtl/ysyx_23060332_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_23060332_ifu
// Instruction fetch unit. Owns the PC and keeps one memory request
// outstanding at a time. It holds the fetched word for decode until decode
// consumes it. On that handoff it applies the execute-stage redirect, or
// falls through to pc+4.
// Ports:
//   clk  : core clock. All state changes on the rising edge.
//   rst  : synchronous reset, active-high.
//   bus  : ysyx_23060332_ifu_if.master. Carries the memory request and
//          response, the decode handoff, the redirect and the error flag.
// ----------------------------------------------------------------------------
module ysyx_23060332_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_23060332_ifu_if.master        bus
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_reg,      state_next;
    logic [31:0] pc_reg,         pc_next;
    logic        req_valid_reg,  req_valid_next;
    logic [31:0] inst_reg,       inst_next;
    logic [31:0] inst_addr_reg,  inst_addr_next;
    logic        inst_valid_reg, inst_valid_next;
    logic        err_reg,        err_next;

    logic        req_fire;
    logic        resp_fire;
    logic        handoff;
    logic [31:0] jump_aligned;

    // Redirect targets are forced onto a word boundary. The two low bits
    // are dropped, and a misaligned target is reported separately.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_align
            if (gi < 2) begin : g_low
                assign jump_aligned[gi] = 1'b0;
            end else begin : g_high
                assign jump_aligned[gi] = bus.jump_addr_i[gi];
            end
        end
    endgenerate

    assign req_fire  = (state_reg == S_REQ)  && req_valid_reg  && bus.imem_req_ready;
    // A response in S_WAIT is acted on even if imem_req_ready is also high.
    assign resp_fire = (state_reg == S_WAIT) && bus.imem_resp_valid;
    assign handoff   = (state_reg == S_HOLD) && inst_valid_reg && bus.inst_ready_i;

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_REQ;
            pc_reg         <= RESET_PC;
            req_valid_reg  <= 1'b0;
            inst_reg       <= NOP_INST;
            inst_addr_reg  <= RESET_PC;
            inst_valid_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            req_valid_reg  <= req_valid_next;
            inst_reg       <= inst_next;
            inst_addr_reg  <= inst_addr_next;
            inst_valid_reg <= inst_valid_next;
            err_reg        <= err_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_REQ:   if (req_fire)  state_next = S_WAIT;
            S_WAIT:  if (resp_fire) state_next = S_HOLD;
            S_HOLD:  if (handoff)   state_next = S_REQ;
            default:                state_next = S_REQ;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        pc_next         = pc_reg;
        req_valid_next  = req_valid_reg;
        inst_next       = inst_reg;
        inst_addr_next  = inst_addr_reg;
        inst_valid_next = inst_valid_reg;
        err_next        = err_reg;

        case (state_reg)
            S_REQ: begin
                // The request rises one cycle after entering S_REQ. It stays
                // high, with pc unchanged, until memory accepts it.
                req_valid_next = !req_fire;
            end
            S_WAIT: begin
                req_valid_next = 1'b0;
                if (resp_fire) begin
                    inst_next       = bus.imem_resp_data;
                    inst_addr_next  = pc_reg;
                    inst_valid_next = 1'b1;
                end
            end
            S_HOLD: begin
                req_valid_next = 1'b0;
                if (handoff) begin
                    pc_next         = bus.jump_flag_i ? jump_aligned : pc_reg + 32'd4;
                    inst_valid_next = 1'b0;
                    inst_next       = NOP_INST;
                    if (bus.jump_flag_i && (bus.jump_addr_i[1:0] != 2'b00))
                        err_next = 1'b1;
                end
            end
            default: begin
                req_valid_next = 1'b0;
            end
        endcase

        // A response outside S_WAIT changes nothing except the error flag.
        if (bus.imem_resp_valid && (state_reg != S_WAIT))
            err_next = 1'b1;
    end

    assign bus.imem_req_valid = req_valid_reg;
    assign bus.imem_req_addr  = pc_reg;
    assign bus.inst_o         = inst_reg;
    assign bus.inst_addr_o    = inst_addr_reg;
    assign bus.inst_valid_o   = inst_valid_reg;
    assign bus.fetch_err_o    = err_reg;

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
module tb_ysyx_23060332_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    ysyx_23060332_ifu_if bus ();

    ysyx_23060332_ifu #(
        .RESET_PC (RST_PC),
        .NOP_INST (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full fetch, starting in S_REQ with the request not yet raised.
    task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                            input logic jf, input logic [31:0] ja);
        bus.imem_req_ready = 1'b1;
        tick();
        check("req_valid_up", bus.imem_req_valid, 1'b1);
        check("req_addr", bus.imem_req_addr, exp_addr);
        tick();
        check("req_valid_drop", bus.imem_req_valid, 1'b0);
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = data;
        tick();
        bus.imem_resp_valid = 1'b0;
        check("inst_valid", bus.inst_valid_o, 1'b1);
        check("inst", bus.inst_o, data);
        check("inst_addr", bus.inst_addr_o, exp_addr);
        bus.inst_ready_i = 1'b1;
        bus.jump_flag_i  = jf;
        bus.jump_addr_i  = ja;
        tick();
        bus.inst_ready_i = 1'b0;
        bus.jump_flag_i  = 1'b0;
        check("handoff_valid", bus.inst_valid_o, 1'b0);
        check("handoff_nop", bus.inst_o, NOP);
        $display("fetch addr=%h data=%h jump=%0b target=%h", exp_addr, data, jf, ja);
    endtask

    initial begin
        rst                 = 1'b1;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.inst_ready_i    = 1'b0;
        bus.jump_flag_i     = 1'b0;
        bus.jump_addr_i     = 32'h0;
        tick();
        rst = 1'b0;
        check("rst_req_valid", bus.imem_req_valid, 1'b0);
        check("rst_inst_valid", bus.inst_valid_o, 1'b0);
        check("rst_inst", bus.inst_o, NOP);
        check("rst_inst_addr", bus.inst_addr_o, RST_PC);
        check("rst_err", bus.fetch_err_o, 1'b0);
        check("rst_req_addr", bus.imem_req_addr, RST_PC);

        // Immediate memory: three sequential fetches.
        do_fetch(32'h8000_0000, 32'h1111_0001, 1'b0, 32'h0);
        do_fetch(32'h8000_0004, 32'h2222_0002, 1'b0, 32'h0);
        do_fetch(32'h8000_0008, 32'h3333_0003, 1'b0, 32'h0);

        // Memory stall from reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.imem_req_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", bus.imem_req_valid, 1'b1);
            check("stall_addr", bus.imem_req_addr, RST_PC);
            tick();
        end
        bus.imem_req_ready = 1'b1;
        tick();
        check("accept_once", bus.imem_req_valid, 1'b0);
        tick();
        check("no_second_req", bus.imem_req_valid, 1'b0);
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h0010_0093;
        tick();
        bus.imem_resp_valid = 1'b0;
        check("bp_capture", bus.inst_valid_o, 1'b1);
        $display("fetch addr=%h data=%h (stalled request)", RST_PC, 32'h0010_0093);

        // Decode backpressure; a redirect offered off-handoff is ignored.
        bus.jump_flag_i = 1'b1;
        bus.jump_addr_i = 32'h9000_0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_inst", bus.inst_o, 32'h0010_0093);
            check("bp_addr", bus.inst_addr_o, RST_PC);
            check("bp_valid", bus.inst_valid_o, 1'b1);
            check("bp_no_req", bus.imem_req_valid, 1'b0);
        end
        bus.jump_flag_i  = 1'b0;
        bus.inst_ready_i = 1'b1;
        tick();
        bus.inst_ready_i = 1'b0;
        check("bp_handoff", bus.inst_valid_o, 1'b0);

        // Walk to 0x80000010, then take an aligned jump and a misaligned one.
        do_fetch(32'h8000_0004, 32'h0000_0a04, 1'b0, 32'h0);
        do_fetch(32'h8000_0008, 32'h0000_0a08, 1'b0, 32'h0);
        do_fetch(32'h8000_000c, 32'h0000_0a0c, 1'b0, 32'h0);
        do_fetch(32'h8000_0010, 32'h0000_0a10, 1'b1, 32'h8000_0100);
        check("aligned_no_err", bus.fetch_err_o, 1'b0);
        do_fetch(32'h8000_0100, 32'h0000_0b00, 1'b1, 32'h8000_0102);
        check("misalign_err", bus.fetch_err_o, 1'b1);
        do_fetch(32'h8000_0100, 32'h0000_0b01, 1'b0, 32'h0);
        check("err_sticky", bus.fetch_err_o, 1'b1);

        // Reset while waiting on memory.
        bus.imem_req_ready = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_inst_valid", bus.inst_valid_o, 1'b0);
        check("rstw_inst", bus.inst_o, NOP);
        check("rstw_req_valid", bus.imem_req_valid, 1'b0);
        check("rstw_err", bus.fetch_err_o, 1'b0);
        do_fetch(32'h8000_0000, 32'h0000_0c00, 1'b0, 32'h0);

        // Reset while holding an instruction for decode.
        bus.imem_req_ready = 1'b1;
        tick();
        tick();
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h0000_0d04;
        tick();
        bus.imem_resp_valid = 1'b0;
        check("hold_addr", bus.inst_addr_o, 32'h8000_0004);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rsth_inst_valid", bus.inst_valid_o, 1'b0);
        check("rsth_inst", bus.inst_o, NOP);
        check("rsth_req_valid", bus.imem_req_valid, 1'b0);
        check("rsth_inst_addr", bus.inst_addr_o, RST_PC);

        // Spurious response while in S_REQ.
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hdead_beef;
        tick();
        bus.imem_resp_valid = 1'b0;
        check("spur_err", bus.fetch_err_o, 1'b1);
        check("spur_inst_valid", bus.inst_valid_o, 1'b0);
        check("spur_inst", bus.inst_o, NOP);
        check("spur_req_valid", bus.imem_req_valid, 1'b1);
        check("spur_req_addr", bus.imem_req_addr, RST_PC);
        $display("spurious response data=%h err=%0b", 32'hdead_beef, bus.fetch_err_o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
